// File: rtl/trigger_csr_file.sv
// trigger_csr_file
// Software-side owner of the debug trigger registers (tselect, tdata1,
// tdata2, tinfo). Accepts CSR requests through a two-state IDLE/RESP
// handshake, legalises written fields, drives per-trigger configuration to
// the comparator and turns comparator matches into sticky hit bits and
// registered fire pulses.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   csr_req/we/addr/wdata   request (accepted while csr_ready=1)
//   csr_ready       block can accept a request this cycle
//   csr_ack/rdata/err       one-cycle response (rdata = pre-write value)
//   debug_mode, priv        hart state
//   match_in        comparator match per trigger
//   tdata2_out, match_mode_out, trig_enable   per-trigger configuration
//   trig_fire, fire_action  registered fire pulse and lowest-index action
module trigger_csr_file #(
  parameter int unsigned num_triggers = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             csr_req,
  output logic                             csr_ready,
  input  logic                             csr_we,
  input  logic [11:0]                      csr_addr,
  input  logic [63:0]                      csr_wdata,
  output logic                             csr_ack,
  output logic [63:0]                      csr_rdata,
  output logic                             csr_err,
  input  logic                             debug_mode,
  input  logic [1:0]                       priv,
  input  logic [num_triggers-1:0]          match_in,
  output logic [num_triggers-1:0][63:0]    tdata2_out,
  output logic [num_triggers-1:0][3:0]     match_mode_out,
  output logic [num_triggers-1:0]          trig_enable,
  output logic [num_triggers-1:0]          trig_fire,
  output logic [3:0]                       fire_action
);

  localparam int unsigned SW = (num_triggers > 1) ? $clog2(num_triggers) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                          state;
  logic [SW-1:0]                   tselect;
  logic [num_triggers-1:0]         dmode_q, hit_q, m_q, s_q, u_q;
  logic [num_triggers-1:0][3:0]    action_q, match_q;
  logic [num_triggers-1:0][63:0]   tdata2_q;

  logic                            accept;
  logic                            locked;
  logic [63:0]                     sel_tdata1;
  logic [63:0]                     acc_rdata;
  logic                            acc_err;
  logic                            wr_sel, wr_t1, wr_t2;
  logic [num_triggers-1:0]         fire_next;
  logic [3:0]                      next_action;
  logic [3:0]                      legal_match;
  logic [3:0]                      legal_action;

  assign tdata2_out     = tdata2_q;
  assign match_mode_out = match_q;

  assign accept = csr_req && (state == IDLE);
  assign locked = dmode_q[tselect] && !debug_mode;

  assign sel_tdata1 = {4'h6, dmode_q[tselect], 36'b0, hit_q[tselect], 6'b0,
                       action_q[tselect], 1'b0, match_q[tselect], m_q[tselect],
                       2'b0, s_q[tselect], u_q[tselect], 2'b0};

  always_comb begin
    case (csr_wdata[10:7])
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
      4'd8, 4'd9, 4'd12, 4'd13: legal_match = csr_wdata[10:7];
      default:                  legal_match = 4'd0;
    endcase
    legal_action = (csr_wdata[15:12] <= 4'd1) ? csr_wdata[15:12] : 4'd0;
  end

  always_comb begin
    trig_enable = '0;
    for (int unsigned i = 0; i < num_triggers; i++) begin
      trig_enable[i] = (m_q[i] && priv == 2'd3) ||
                       (s_q[i] && priv == 2'd1) ||
                       (u_q[i] && priv == 2'd0);
    end
  end

  assign fire_next = match_in & trig_enable & {num_triggers{!debug_mode}};

  // Lowest firing index wins the action slot.
  always_comb begin
    logic found;
    next_action = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < num_triggers; i++) begin
      if (fire_next[i] && !found) begin
        next_action = action_q[i];
        found       = 1'b1;
      end
    end
  end

  // Address decode; response data is always taken from pre-edge state.
  always_comb begin
    acc_rdata = '0;
    acc_err   = 1'b0;
    wr_sel    = 1'b0;
    wr_t1     = 1'b0;
    wr_t2     = 1'b0;
    case (csr_addr)
      12'h7A0: begin
        acc_rdata = 64'(tselect);
        wr_sel    = csr_we;
      end
      12'h7A1: begin
        acc_rdata = sel_tdata1;
        if (csr_we) begin
          if (locked) acc_err = 1'b1;
          else        wr_t1   = 1'b1;
        end
      end
      12'h7A2: begin
        acc_rdata = tdata2_q[tselect];
        if (csr_we) begin
          if (locked) acc_err = 1'b1;
          else        wr_t2   = 1'b1;
        end
      end
      12'h7A4: acc_rdata = 64'h40;
      default: acc_err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      csr_ready   <= 1'b1;
      csr_ack     <= 1'b0;
      csr_rdata   <= '0;
      csr_err     <= 1'b0;
      tselect     <= '0;
      dmode_q     <= '0;
      hit_q       <= '0;
      m_q         <= '0;
      s_q         <= '0;
      u_q         <= '0;
      action_q    <= '0;
      match_q     <= '0;
      tdata2_q    <= '0;
      trig_fire   <= '0;
      fire_action <= '0;
    end else begin
      trig_fire   <= fire_next;
      fire_action <= next_action;

      // A same-edge hardware hit overrides the software-written hit bit.
      for (int unsigned i = 0; i < num_triggers; i++) begin
        if (accept && wr_t1 && tselect == SW'(i)) begin
          dmode_q[i]  <= debug_mode && csr_wdata[59];
          hit_q[i]    <= csr_wdata[22] || fire_next[i];
          action_q[i] <= legal_action;
          match_q[i]  <= legal_match;
          m_q[i]      <= csr_wdata[6];
          s_q[i]      <= csr_wdata[3];
          u_q[i]      <= csr_wdata[2];
        end else if (fire_next[i]) begin
          hit_q[i] <= 1'b1;
        end
      end

      if (accept && wr_t2)
        tdata2_q[tselect] <= csr_wdata;
      if (accept && wr_sel && csr_wdata < 64'(num_triggers))
        tselect <= csr_wdata[SW-1:0];

      case (state)
        IDLE: begin
          if (csr_req) begin
            state     <= RESP;
            csr_ready <= 1'b0;
            csr_ack   <= 1'b1;
            csr_rdata <= acc_rdata;
            csr_err   <= acc_err;
          end
        end
        RESP: begin
          state     <= IDLE;
          csr_ready <= 1'b1;
          csr_ack   <= 1'b0;
          csr_rdata <= '0;
          csr_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_csr_file.sv
module tb_trigger_csr_file;

  logic             clk = 1'b0;
  logic             rst;
  logic             csr_req;
  logic             csr_ready;
  logic             csr_we;
  logic [11:0]      csr_addr;
  logic [63:0]      csr_wdata;
  logic             csr_ack;
  logic [63:0]      csr_rdata;
  logic             csr_err;
  logic             debug_mode;
  logic [1:0]       priv;
  logic [3:0]       match_in;
  logic [3:0][63:0] tdata2_out;
  logic [3:0][3:0]  match_mode_out;
  logic [3:0]       trig_enable;
  logic [3:0]       trig_fire;
  logic [3:0]       fire_action;

  int checks = 0;
  int errors = 0;

  logic [63:0] rd;
  logic        er;

  always #5 clk = ~clk;

  trigger_csr_file #(.num_triggers(4)) dut (
    .clk(clk), .rst(rst),
    .csr_req(csr_req), .csr_ready(csr_ready), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_err(csr_err),
    .debug_mode(debug_mode), .priv(priv), .match_in(match_in),
    .tdata2_out(tdata2_out), .match_mode_out(match_mode_out),
    .trig_enable(trig_enable), .trig_fire(trig_fire), .fire_action(fire_action)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CSR transaction; mi is applied to match_in during the accept cycle.
  task automatic csr(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                     input logic [3:0] mi, output logic [63:0] rdo, output logic erro);
    @(negedge clk);
    chk("ready_idle", 64'(csr_ready), 64'd1);
    csr_req = 1'b1; csr_we = we; csr_addr = addr; csr_wdata = wd; match_in = mi;
    @(posedge clk); #1;
    csr_req = 1'b0; csr_we = 1'b0; match_in = '0;
    chk("ack_after_accept", 64'(csr_ack), 64'd1);
    chk("ready_low_in_ack", 64'(csr_ready), 64'd0);
    rdo  = csr_rdata;
    erro = csr_err;
    @(posedge clk); #1;
    chk("ack_single_cycle", 64'(csr_ack), 64'd0);
  endtask

  task automatic wr(input string tag, input logic [11:0] addr, input logic [63:0] wd,
                    input logic exp_err);
    logic [63:0] r; logic e;
    csr(1'b1, addr, wd, 4'b0, r, e);
    chk(tag, 64'(e), 64'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [63:0] exp,
                        input logic exp_err);
    logic [63:0] r; logic e;
    csr(1'b0, addr, 64'd0, 4'b0, r, e);
    chk(tag, r, exp);
    chk({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  task automatic pulse(input string tag, input logic [3:0] mi, input logic [3:0] exp_fire,
                       input logic [3:0] exp_act);
    @(negedge clk);
    match_in = mi;
    @(posedge clk); #1;
    chk({tag, "_fire"}, 64'(trig_fire), 64'(exp_fire));
    chk({tag, "_action"}, 64'(fire_action), 64'(exp_act));
    @(negedge clk);
    match_in = '0;
    @(posedge clk); #1;
    chk({tag, "_fire_drop"}, 64'(trig_fire), 64'd0);
  endtask

  initial begin
    rst = 1'b0; csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    debug_mode = 1'b0; priv = 2'd3; match_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(csr_ready), 64'd1);
    chk("rst_ack", 64'(csr_ack), 64'd0);
    chk("rst_rdata", csr_rdata, 64'd0);
    chk("rst_fire", 64'(trig_fire), 64'd0);
    @(negedge clk) rst = 1'b1;

    rd_chk("tdata1_reset", 12'h7A1, 64'h6000_0000_0000_0000, 1'b0);
    rd_chk("tinfo", 12'h7A4, 64'h40, 1'b0);

    // Reset asserted while the response is pending
    @(negedge clk);
    csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'h7A2; csr_wdata = 64'hDEAD;
    @(posedge clk); #1;
    csr_req = 1'b0; csr_we = 1'b0;
    chk("mid_ack_before_rst", 64'(csr_ack), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", 64'(csr_ack), 64'd0);
    chk("mid_rst_ready", 64'(csr_ready), 64'd1);
    chk("mid_rst_tdata2", tdata2_out[0], 64'd0);
    @(negedge clk) rst = 1'b1;
    rd_chk("post_rst_tdata1", 12'h7A1, 64'h6000_0000_0000_0000, 1'b0);
    rd_chk("post_rst_tinfo", 12'h7A4, 64'h40, 1'b0);
    rd_chk("post_rst_tdata2", 12'h7A2, 64'd0, 1'b0);

    // Legalisation on trigger 2 (type/dmode bits written but ignored)
    wr("sel2", 12'h7A0, 64'd2, 1'b0);
    rd_chk("tsel_is2", 12'h7A0, 64'd2, 1'b0);
    wr("t1_illegal", 12'h7A1, 64'hF800_0000_0000_3344, 1'b0);
    rd_chk("t1_legalised", 12'h7A1, 64'h6000_0000_0000_0044, 1'b0);
    chk("match_out_0", 64'(match_mode_out[2]), 64'd0);
    wr("t1_match9", 12'h7A1, 64'h14C0, 1'b0);
    rd_chk("t1_match9_rd", 12'h7A1, 64'h6000_0000_0000_14C0, 1'b0);
    chk("match_out_9", 64'(match_mode_out[2]), 64'd9);
    chk("enable_t2_m", 64'(trig_enable), 64'b0100);

    // tselect range and address errors
    wr("sel7", 12'h7A0, 64'd7, 1'b0);
    rd_chk("tsel_kept", 12'h7A0, 64'd2, 1'b0);
    rd_chk("addr_7a3", 12'h7A3, 64'd0, 1'b1);
    wr("addr_7a3_wr", 12'h7A3, 64'h1, 1'b1);
    csr(1'b1, 12'h7A4, 64'h5, 4'b0, rd, er);
    chk("tinfo_wr_rdata", rd, 64'h40);
    chk("tinfo_wr_err", 64'(er), 64'd0);

    // dmode lock on trigger 1
    wr("sel1", 12'h7A0, 64'd1, 1'b0);
    debug_mode = 1'b1;
    wr("set_dmode", 12'h7A1, 64'h0800_0000_0000_0000, 1'b0);
    rd_chk("dmode_rd", 12'h7A1, 64'h6800_0000_0000_0000, 1'b0);
    debug_mode = 1'b0;
    wr("locked_t2", 12'h7A2, 64'h1234, 1'b1);
    chk("locked_t2_val", tdata2_out[1], 64'd0);
    wr("locked_t1", 12'h7A1, 64'h40, 1'b1);
    rd_chk("locked_t1_rd", 12'h7A1, 64'h6800_0000_0000_0000, 1'b0);
    debug_mode = 1'b1;
    csr(1'b1, 12'h7A2, 64'h1234, 4'b0, rd, er);
    chk("dbg_t2_err", 64'(er), 64'd0);
    chk("dbg_t2_oldval", rd, 64'd0);
    chk("dbg_t2_val", tdata2_out[1], 64'h1234);
    wr("t1_cfg", 12'h7A1, 64'h1040, 1'b0);
    debug_mode = 1'b0;
    rd_chk("t1_cfg_rd", 12'h7A1, 64'h6000_0000_0000_1040, 1'b0);

    // Fire on trigger 0
    wr("sel0", 12'h7A0, 64'd0, 1'b0);
    wr("t0_cfg", 12'h7A1, 64'h1040, 1'b0);
    pulse("fire0", 4'b0001, 4'b0001, 4'd1);
    rd_chk("hit0", 12'h7A1, 64'h6000_0000_0040_1040, 1'b0);
    priv = 2'd0;
    #1;
    chk("enable_u", 64'(trig_enable), 64'd0);
    pulse("nofire_u", 4'b0001, 4'b0000, 4'd0);
    priv = 2'd3;

    // Software hit clear racing a hardware hit
    wr("clr_hit", 12'h7A1, 64'h1040, 1'b0);
    rd_chk("hit_cleared", 12'h7A1, 64'h6000_0000_0000_1040, 1'b0);
    csr(1'b1, 12'h7A1, 64'h1040, 4'b0001, rd, er);
    chk("collide_err", 64'(er), 64'd0);
    rd_chk("collide_hit", 12'h7A1, 64'h6000_0000_0040_1040, 1'b0);

    // Triggers 1 (action 1) and 3 (action 0) together
    wr("sel3", 12'h7A0, 64'd3, 1'b0);
    wr("t3_cfg", 12'h7A1, 64'h40, 1'b0);
    pulse("fire13", 4'b1010, 4'b1010, 4'd1);
    rd_chk("hit3", 12'h7A1, 64'h6000_0000_0040_0040, 1'b0);

    debug_mode = 1'b1;
    pulse("nofire_dbg", 4'b0001, 4'b0000, 4'd0);
    debug_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_csr_file.md
Name: trigger_csr_file

Overview:
- Software-side owner of the debug trigger registers (tselect, tdata1, tdata2, tinfo).
- Accepts CSR read/write requests and legalises written fields.
- Drives per-trigger tdata2, match mode and enable to the trigger comparator.
- Consumes the comparator's per-trigger match results to set sticky hit bits and issue registered fire pulses with the programmed action.

Parameters:
num_triggers, 4, number of trigger register sets (1..16)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
csr_req  input  1  request valid
csr_ready  output  1  block can accept request this cycle
csr_we  input  1  1=write, 0=read
csr_addr  input  12  CSR address
csr_wdata  input  64  write data
csr_ack  output  1  one-cycle response valid
csr_rdata  output  64  read data, valid with csr_ack (old value on write)
csr_err  output  1  unknown address or denied access, valid with csr_ack
debug_mode  input  1  hart in debug mode
priv  input  2  current privilege (0=U, 1=S, 3=M)
match_in  input  num_triggers  comparator Match result per trigger
tdata2_out  output  64 x num_triggers  tdata2 per trigger
match_mode_out  output  4 x num_triggers  match field per trigger
trig_enable  output  num_triggers  trigger armed for current priv
trig_fire  output  num_triggers  registered one-cycle fire pulse
fire_action  output  4  action of lowest-index firing trigger, valid with any trig_fire bit

Behaviour:
- Reset (rst low, asynchronous):
  - tselect=0.
  - All tdata1 = type 6 with all writable fields 0.
  - All tdata2=0.
  - State IDLE.
  - csr_ready=1; csr_ack, csr_err, trig_fire, fire_action = 0.
  - csr_rdata=0.
- tdata1 layout: [63:60] type, RO=6; [59] dmode; [22] hit; [15:12] action; [10:7] match; [6] m; [3] s; [2] u; all other bits RO 0.
- Addresses:
  - 0x7A0 tselect.
  - 0x7A1 tdata1[tselect].
  - 0x7A2 tdata2[tselect].
  - 0x7A4 tinfo: RO, reads 64'h40; writes ignored, no error.
  - Any other address: csr_err=1, rdata=0, no state change.
- FSM IDLE/RESP:
  - IDLE: csr_ready=1. csr_req samples address/data; write commits at that edge; go to RESP.
  - RESP: csr_ack=1 with rdata/err; csr_ready=0. Always return to IDLE next cycle.
  - Result: max one request per 2 cycles; latency 1 cycle from accept to ack.
- tselect write: value >= num_triggers is ignored (retains old value); no error.
- tdata1/tdata2 writes:
  - If the selected trigger has dmode=1 and debug_mode=0, the write is ignored and csr_err=1.
  - dmode is writable only when debug_mode=1; otherwise the written bit is forced 0.
- Legalisation on tdata1 write:
  - match in {0,1,2,3,4,5,8,9,12,13} is kept; any other value stores 0.
  - action in {0,1} is kept; any other value stores 0.
  - RO bits ignored.
- trig_enable[i] = (m & priv==3) | (s & priv==1) | (u & priv==0), combinational from stored fields and priv.
- Fire:
  - At each edge, trig_fire[i] <= match_in[i] & trig_enable[i] & ~debug_mode.
  - On the same edge, hit[i] is set sticky.
  - fire_action is registered in the same cycle from the lowest firing index.
- Simultaneous software write of tdata1[i] and hit-set: hit set wins (hit=1). Other fields take the written values.
- Reset mid-transaction: FSM to IDLE, pending ack dropped; no partial write is visible.
- Read data reflects state before any same-edge write or hit update.

Test Plan:
- Reset: drive rst low mid-RESP -> csr_ack=0, csr_ready=1, tdata1[0] reads 64'h6000_0000_0000_0000, tinfo reads 64'h40.
- Legalisation:
  - Select trigger 2.
  - Write tdata1 = match 6, action 3, m=1, u=1 -> readback match=0, action=0, m=1, u=1, type=6.
  - Write match=9 -> match_mode_out[2]=9.
- Select/addr errors:
  - Write tselect=7 with num_triggers=4 -> tselect stays at previous value.
  - Access 0x7A3 -> csr_err=1, rdata=0.
  - Check ack exactly 1 cycle after accept, and csr_ready=0 during ack.
- dmode lock:
  - With debug_mode=1, set dmode on trigger 1.
  - With debug_mode=0, write tdata2 -> csr_err=1, tdata2_out[1] unchanged.
  - With debug_mode=1 the same write succeeds.
- Fire:
  - Trigger 0: m=1, action=1; priv=3; pulse match_in[0] for 1 cycle -> trig_fire[0]=1 one cycle later for exactly 1 cycle, fire_action=1, hit reads 1.
  - priv=0 -> no fire.
- Collision:
  - Software writes tdata1[0] with hit=0 on the same edge match_in[0] fires -> hit reads 1.
  - Triggers 1 and 3 fire together -> fire_action = trigger 1's action.
